fma_vector_checker: RTL
=======================

// Module: fma_vector_checker
// PURPOSE
//   Synthesizable, parametrised successor to the fma16 vector bench: holds a vector RAM of
//   {x,y,z,ctrl,rexpected,flagsexpected} entries, streams operands to a (possibly pipelined)
//   FMA under test with valid/ready handshake, matches returning results in order against
//   expected values, and reports error count, first failing index and completion.
// PARAMETERS
//   FLEN      16    operand/result width
//   NF        4     flag width {invalid,overflow,underflow,inexact}
//   CTRLW     8     ctrl field width (roundmode,mul,add,negp,negz in [5:0])
//   DEPTH     1024  vector RAM entries (power of 2); AW = $clog2(DEPTH)
//   EXPQ      8     in-flight expected-value queue depth (power of 2), >= DUT latency
//   FLAGCHK   1     1: mismatch includes flags; 0: result only
// PORTS
//   clk          in   1          clock
//   reset_n      in   1          asynchronous reset, active low
//   ld_en        in   1          write vector RAM (ignored while busy)
//   ld_addr      in   AW         RAM write address
//   ld_data      in   VW         vector, VW=4*FLEN+CTRLW+NF, packed {x,y,z,ctrl,rexp,fexp}
//   num_vec      in   AW+1       vectors to run (sampled on start)
//   start        in   1          pulse: begin run (ignored unless IDLE or DONE)
//   op_valid     out  1          operands valid to DUT
//   op_ready     in   1          DUT accepts operands
//   x,y,z        out  FLEN       operands
//   ctrl         out  CTRLW      control field
//   res_valid    in   1          DUT result valid (in issue order)
//   result       in   FLEN       DUT result
//   flags        in   NF         DUT flags
//   busy         out  1          run in progress (RUN or DRAIN)
//   done         out  1          run finished; held until next start
//   err_pulse    out  1          one-cycle pulse on each mismatch
//   errors       out  32         mismatch count, saturating at 32'hFFFF_FFFF
//   first_err    out  AW+1       index of first mismatch; all-ones if none
//   proto_err    out  1          sticky: res_valid with empty queue or queue overflow
// BEHAVIOUR
//   Reset (async, reset_n=0): state IDLE; op_valid,busy,done,err_pulse,proto_err=0;
//     errors=0; first_err=all-ones; issue/compare pointers and queue cleared. RAM not reset.
//   FSM: IDLE -start-> RUN (num_vec>0) or DONE (num_vec==0, next cycle);
//     RUN -last vector handshaken-> DRAIN; DRAIN -queue empty-> DONE; DONE -start-> RUN/DONE.
//   start clears errors, first_err, proto_err, done and pointers in the same edge.
//   Issue: RAM read is synchronous (1-cycle); op_valid asserts 1 cycle after entering RUN.
//     x/y/z/ctrl stable while op_valid & ~op_ready. Handshake = op_valid & op_ready;
//     on handshake push {rexp,fexp,idx} into queue and present next vector the following
//     cycle (back-to-back issue at 1/cycle sustained). op_valid drops when queue full,
//     and after last vector is issued.
//   Compare: on res_valid pop head; mismatch = result!==rexp | (FLAGCHK & flags!==fexp).
//     Mismatch -> err_pulse next cycle, errors+1 (saturating), first_err=idx if still all-ones.
//   Simultaneous push and pop in same cycle allowed at any occupancy including full.
//   res_valid with empty queue: proto_err=1, no count change. res_valid never stalled.
//   done rises the cycle after the final pop; errors/first_err stable while done=1.
//   ld_en while busy: write dropped. start while busy: ignored.
//   reset_n asserted mid-run: everything returns to reset state immediately; run aborted.
// TESTING
//   Load 4 vectors incl. 3c00*3c00+0000 ->3c00 f=0, DUT latency 0, op_ready=1 -> 4 issues in
//     4 consecutive cycles, done=1, errors=0, first_err=all-ones.
//   Vector 2 expects 4000 but DUT returns 3c00 -> single err_pulse, errors=1, first_err=2.
//   Model DUT latency 5 with EXPQ=8, op_ready toggling 1/0 -> operands hold while stalled,
//     all 16 vectors compared in order, no proto_err.
//   FLAGCHK=0, result matches but flags 0001 vs 0000 -> errors=0; FLAGCHK=1 -> errors=1.
//   start with num_vec=0 -> done=1 next-but-one cycle, op_valid never asserted.
//   reset_n low during RUN with 3 in flight -> op_valid=0, errors=0, state IDLE; spurious
//     res_valid after reset -> proto_err=1.

Source files
------------

// File: rtl/fma_vector_checker.sv
// fma_vector_checker
//   Vector-driven checker for an FMA unit. Holds a vector RAM of
//   {x, y, z, ctrl, rexp, fexp} entries, streams operands to the FMA under
//   test over a valid/ready handshake, keeps the expected values of in-flight
//   operations in a FIFO, and compares the results returned in order.
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data   vector RAM write port (dropped while busy)
//   num_vec, start          run length and run trigger (IDLE or DONE only)
//   op_valid/op_ready       operand handshake; x, y, z, ctrl operands
//   res_valid/result/flags  returned results, never stalled, in issue order
//   busy, done              run status (done held until the next start)
//   err_pulse, errors       per-mismatch pulse, saturating mismatch count
//   first_err               index of the first mismatch, all-ones if none
//   proto_err               sticky: result with nothing in flight, or overflow
module fma_vector_checker #(
  parameter int unsigned FLEN    = 16,
  parameter int unsigned NF      = 4,
  parameter int unsigned CTRLW   = 8,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned EXPQ    = 8,
  parameter int unsigned FLAGCHK = 1,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned VW = 4*FLEN + CTRLW + NF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [VW-1:0]    ld_data,
  input  logic [AW:0]      num_vec,
  input  logic             start,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [FLEN-1:0]  x,
  output logic [FLEN-1:0]  y,
  output logic [FLEN-1:0]  z,
  output logic [CTRLW-1:0] ctrl,
  input  logic             res_valid,
  input  logic [FLEN-1:0]  result,
  input  logic [NF-1:0]    flags,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic [31:0]      errors,
  output logic [AW:0]      first_err,
  output logic             proto_err
);

  localparam int unsigned QAW    = $clog2(EXPQ);
  localparam int unsigned QW     = FLEN + NF + AW + 1;
  localparam int unsigned F_REXP = NF;
  localparam int unsigned F_CTRL = NF + FLEN;
  localparam int unsigned F_Z    = F_CTRL + CTRLW;
  localparam int unsigned F_Y    = F_Z + FLEN;
  localparam int unsigned F_X    = F_Y + FLEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;

  logic [VW-1:0]   vec_mem [DEPTH];
  logic [VW-1:0]   rd_data_q;
  logic [AW-1:0]   rd_addr;

  logic [AW:0]     issue_idx_q, issue_idx_d;
  logic [AW:0]     num_vec_q, num_vec_d;
  logic            fetched_q, fetched_d;

  logic [QW-1:0]   q_mem [EXPQ];
  logic [QAW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [QAW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [QAW:0]    cnt_q, cnt_d;

  logic            err_pulse_q, err_pulse_d;
  logic [31:0]     errors_q, errors_d;
  logic [AW:0]     first_err_q, first_err_d;
  logic            proto_err_q, proto_err_d;

  logic            start_ok, q_empty, q_full;
  logic            hs, pop, mismatch, last_issue;
  logic [QW-1:0]   push_entry, head_entry;
  logic [FLEN-1:0] head_rexp;
  logic [NF-1:0]   head_fexp;
  logic [AW:0]     head_idx;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign q_empty  = (cnt_q == '0);
  assign q_full   = (cnt_q == (QAW+1)'(EXPQ));

  // Read address runs one ahead on a handshake so the next vector is on the
  // operand bus the following cycle; otherwise the current vector is re-read,
  // keeping operands stable through a stall.
  assign rd_addr = issue_idx_q[AW-1:0] + AW'(hs);

  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      vec_mem[ld_addr] <= ld_data;
    end
    rd_data_q <= vec_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      q_mem[wr_ptr_q] <= push_entry;
    end
  end

  assign x    = rd_data_q[F_X +: FLEN];
  assign y    = rd_data_q[F_Y +: FLEN];
  assign z    = rd_data_q[F_Z +: FLEN];
  assign ctrl = rd_data_q[F_CTRL +: CTRLW];

  // With an empty queue the head is the entry being pushed this cycle, so a
  // zero-latency FMA can return its result in the issue cycle.
  always_comb begin
    hs         = op_valid && op_ready;
    push_entry = {rd_data_q[F_REXP +: FLEN], rd_data_q[0 +: NF], issue_idx_q};
    head_entry = q_empty ? push_entry : q_mem[rd_ptr_q];
    head_idx   = head_entry[AW:0];
    head_fexp  = head_entry[AW+1 +: NF];
    head_rexp  = head_entry[AW+1+NF +: FLEN];
    pop        = res_valid && (!q_empty || hs);
    mismatch   = pop && ((result != head_rexp) ||
                         ((FLAGCHK != 0) && (flags != head_fexp)));
    last_issue = hs && (issue_idx_q == num_vec_q - (AW+1)'(1));

    issue_idx_d = issue_idx_q;
    num_vec_d   = num_vec_q;
    fetched_d   = (state_q == S_RUN);
    wr_ptr_d    = wr_ptr_q + QAW'(hs);
    rd_ptr_d    = rd_ptr_q + QAW'(pop);
    cnt_d       = cnt_q + (QAW+1)'(hs) - (QAW+1)'(pop);
    err_pulse_d = mismatch;
    errors_d    = errors_q;
    first_err_d = first_err_q;
    proto_err_d = proto_err_q;

    if (hs) begin
      issue_idx_d = issue_idx_q + (AW+1)'(1);
    end
    if (mismatch) begin
      if (errors_q != '1) begin
        errors_d = errors_q + 32'd1;
      end
      if (first_err_q == '1) begin
        first_err_d = head_idx;
      end
    end
    if (res_valid && q_empty && !hs) begin
      proto_err_d = 1'b1;
    end
    if (hs && q_full && !pop) begin
      proto_err_d = 1'b1;
    end

    if (start_ok) begin
      issue_idx_d = '0;
      num_vec_d   = num_vec;
      fetched_d   = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      err_pulse_d = 1'b0;
      errors_d    = '0;
      first_err_d = '1;
      proto_err_d = 1'b0;
    end
  end

  // A zero-length run passes through RUN for one cycle so that done appears
  // the cycle after next, same as a run whose RAM fetch produced nothing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (num_vec_q == '0)  state_d = S_DONE;
        else if (last_issue)  state_d = (cnt_d == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_valid = (state_q == S_RUN) && fetched_q && (issue_idx_q < num_vec_q) && !q_full;
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      issue_idx_q <= '0;
      num_vec_q   <= '0;
      fetched_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      errors_q    <= '0;
      first_err_q <= '1;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      num_vec_q   <= num_vec_d;
      fetched_q   <= fetched_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      errors_q    <= errors_d;
      first_err_q <= first_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign errors    = errors_q;
  assign first_err = first_err_q;
  assign proto_err = proto_err_q;

endmodule
